// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with single-cycle arithmetic/logic/shift ops and
// multi-cycle unsigned multiply, divide and remainder. A request is taken on
// in_valid & in_ready; the result and flags appear registered with a
// one-cycle out_valid pulse.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [4:0]       OP_MUL  = 5'd16;
  localparam logic [4:0]       OP_DIVU = 5'd17;
  localparam logic [4:0]       OP_REMU = 5'd18;
  localparam logic [WIDTH-1:0] WIDTH_L = WIDTH'(WIDTH);

  state_t state_q, state_d;

  // Captured request
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;

  // Iterative engine
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] mul_q;    // {partial product high, multiplier/low}
  logic [WIDTH:0]     rem_q;    // restoring-divider partial remainder
  logic [WIDTH-1:0]   quo_q;    // dividend shifting out, quotient shifting in

  logic             accept;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;

  // Single-cycle datapath
  logic [WIDTH:0]          add_sum, sub_diff;
  logic                    sh_sat;
  logic [SHW-1:0]          sh;
  logic signed [WIDTH-1:0] asr;
  logic [WIDTH-1:0]        fin_res;
  logic                    fin_c, fin_v, fin_zn;
  logic [3:0]              fin_flags;

  assign accept   = in_valid & in_ready;
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == CALC);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of block order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (op inside {OP_MUL, OP_DIVU, OP_REMU}) ? CALC : DONE;
      CALC: if (cnt_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept; later input changes are ignored
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers carry no reset; they are always loaded
    // before being read, so a reset would only cost routing.
    if (accept) begin
      op_q  <= op;
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
    end
  end

  // One shift-add / shift-subtract step per CALC cycle
  assign mul_sum   = {1'b0, mul_q[2*WIDTH-1:WIDTH]} + (mul_q[0] ? {1'b0, a_q} : '0);
  assign div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  // The top remainder bit is always clear after a restoring step; folding it
  // into the compare keeps the full register meaningful.
  assign div_ok    = rem_q[WIDTH] | (div_shift >= {1'b0, b_q});

  // Iteration registers: load on accept, step while in CALC
  always_ff @(posedge clk) begin
    if (accept) begin
      cnt_q <= SHW'(WIDTH - 1);
      mul_q <= {{WIDTH{1'b0}}, b};
      rem_q <= '0;
      quo_q <= a;
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q - SHW'(1);
      mul_q <= {mul_sum, mul_q[WIDTH-1:1]};
      rem_q <= div_ok ? div_diff : div_shift;
      quo_q <= {quo_q[WIDTH-2:0], div_ok};
    end
  end

  // Single-cycle arithmetic on the captured operands
  assign add_sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q & (op_q == 5'd1)};
  assign sub_diff = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q & (op_q == 5'd3)};
  assign sh_sat   = (b_q >= WIDTH_L);
  assign sh       = b_q[SHW-1:0];
  // NOTE: the arithmetic shift lives in its own signed signal; inside a mux
  // with unsigned operands it would silently become a logical shift.
  assign asr      = $signed(a_q) >>> sh;

  // Final result / flag selection for the operation in flight
  always_comb begin
    fin_res = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    fin_zn  = 1'b1;
    case (op_q)
      5'd0, 5'd1: begin
        fin_res = add_sum[WIDTH-1:0];
        fin_c   = add_sum[WIDTH];
        fin_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      5'd2, 5'd3: begin
        fin_res = sub_diff[WIDTH-1:0];
        fin_c   = sub_diff[WIDTH];
        fin_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      5'd4:  fin_res = a_q & b_q;
      5'd5:  fin_res = a_q | b_q;
      5'd6:  fin_res = a_q ^ b_q;
      5'd7:  fin_res = ~(a_q ^ b_q);
      5'd8:  fin_res = a_q & ~b_q;
      5'd9:  fin_res = a_q | ~b_q;
      5'd10: begin fin_res = sh_sat ? '0 : (a_q << sh); fin_zn = 1'b0; end
      5'd11: begin fin_res = sh_sat ? '0 : (a_q >> sh); fin_zn = 1'b0; end
      5'd12: begin fin_res = sh_sat ? {WIDTH{a_q[WIDTH-1]}} : asr; fin_zn = 1'b0; end
      5'd13: begin fin_res = a_q;  fin_zn = 1'b0; end
      5'd14: begin fin_res = b_q;  fin_zn = 1'b0; end
      5'd15: begin fin_res = ~b_q; fin_zn = 1'b0; end
      OP_MUL: begin
        fin_res = mul_q[WIDTH-1:0];
        fin_c   = |mul_q[2*WIDTH-1:WIDTH];
        fin_v   = fin_c;
      end
      OP_DIVU: begin
        fin_res = quo_q;
        fin_v   = (b_q == '0);
      end
      OP_REMU: begin
        fin_res = rem_q[WIDTH-1:0];
        fin_v   = (b_q == '0);
      end
      default: fin_v = 1'b1;   // illegal op: result 0, Z=1 from the zero result
    endcase
    fin_flags = fin_zn ? {(fin_res == '0), fin_res[WIDTH-1], fin_c, fin_v} : 4'b0000;
  end

  // Registered outputs, written only in DONE and held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_q == DONE);
      if (state_q == DONE) begin
        result <= fin_res;
        flags  <= fin_flags;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32 and WIDTH=16.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid32, in_valid16;
  logic        in_ready32, in_ready16;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        cin;
  logic        out_valid32, out_valid16;
  logic [31:0] result32;
  logic [15:0] result16;
  logic [3:0]  flags32, flags16;
  logic        busy32, busy16;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t vq[$];

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
    .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid32),
    .result(result32), .flags(flags32), .busy(busy32)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .op(op), .a(a[15:0]), .b(b[15:0]), .cin(cin), .out_valid(out_valid16),
    .result(result16), .flags(flags16), .busy(busy16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic add(input logic [4:0] o, input logic [31:0] va, vb, input logic vc,
                     input logic [31:0] r, input logic [3:0] f, input int l);
    vq.push_back('{o, va, vb, vc, r, f, l});
  endtask

  // Issue one request (called at a negedge), scramble inputs after accept,
  // wait for out_valid with a bound. Returns at the negedge showing out_valid.
  task automatic run(input bit w16, input logic [4:0] o, input logic [31:0] va, vb,
                     input logic vc, output logic [31:0] res, output logic [3:0] flg,
                     output int lat, output int acc_cyc);
    int guard = 0;
    while (!(w16 ? in_ready16 : in_ready32) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    op = o; a = va; b = vb; cin = vc;
    if (w16) in_valid16 = 1'b1; else in_valid32 = 1'b1;
    @(negedge clk);
    acc_cyc    = cyc;
    in_valid16 = 1'b0;
    in_valid32 = 1'b0;
    op = 5'd6; a = ~va; b = ~vb; cin = ~vc;
    lat = 0;
    while (!(w16 ? out_valid16 : out_valid32) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = w16 ? {16'h0, result16} : result32;
    flg = w16 ? flags16 : flags32;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid32 = 1'b0; in_valid16 = 1'b0;
    op = '0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (result32 !== 32'h0) $display("FAIL reset_result got %h want 0", result32); else pass_cnt++;
    total_cnt++; if (flags32 !== 4'h0) $display("FAIL reset_flags got %b want 0000", flags32); else pass_cnt++;
    total_cnt++; if (out_valid32 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid32); else pass_cnt++;
    total_cnt++; if (busy32 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy32); else pass_cnt++;
    total_cnt++; if (in_ready32 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready32); else pass_cnt++;
    total_cnt++; if (result16 !== 16'h0 || flags16 !== 4'h0) $display("FAIL reset16 got %h/%b want 0/0000", result16, flags16); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_ops32();
    logic [31:0] res; logic [3:0] flg; int lat, acc;
    vq.delete();
    add(5'd0,  32'h77315843, 32'h31539734, 1'b0, 32'hA884EF77, 4'b0101, 1);
    add(5'd1,  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b1010, 1);
    add(5'd2,  32'h00000001, 32'h00000002, 1'b0, 32'hFFFFFFFF, 4'b0110, 1);
    add(5'd3,  32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b1000, 1);
    add(5'd3,  32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 4'b0110, 1);
    add(5'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4'b1000, 1);
    add(5'd9,  32'h12345678, 32'hFFFF0000, 1'b0, 32'h1234FFFF, 4'b0000, 1);
    add(5'd11, 32'h80000000, 32'd31,       1'b0, 32'h00000001, 4'b0000, 1);
    add(5'd11, 32'hFFFFFFFF, 32'h80000001, 1'b0, 32'h00000000, 4'b0000, 1);
    add(5'd12, 32'h8FFFFFF1, 32'd3,        1'b0, 32'hF1FFFFFE, 4'b0000, 1);
    add(5'd12, 32'h8FFFFFF1, 32'd40,       1'b0, 32'hFFFFFFFF, 4'b0000, 1);
    add(5'd10, 32'h8FFFFFF1, 32'd32,       1'b0, 32'h00000000, 4'b0000, 1);
    add(5'd13, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF, 4'b0000, 1);
    add(5'd15, 32'h0,        32'h0,        1'b0, 32'hFFFFFFFF, 4'b0000, 1);
    add(5'd16, 32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 4'b1011, 33);
    add(5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 4'b0011, 33);
    add(5'd17, 32'd100,      32'd7,        1'b0, 32'd14,       4'b0000, 33);
    add(5'd18, 32'd100,      32'd7,        1'b0, 32'd2,        4'b0000, 33);
    add(5'd17, 32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 4'b0100, 33);
    add(5'd17, 32'd100,      32'd0,        1'b0, 32'hFFFFFFFF, 4'b0101, 33);
    add(5'd18, 32'd100,      32'd0,        1'b0, 32'd100,      4'b0001, 33);
    add(5'd25, 32'h12345678, 32'h9,        1'b1, 32'h00000000, 4'b1001, 1);
    add(5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4'b1001, 1);
    for (int i = 0; i < vq.size(); i++) begin
      run(1'b0, vq[i].op, vq[i].a, vq[i].b, vq[i].cin, res, flg, lat, acc);
      total_cnt++;
      if (res !== vq[i].res) $display("FAIL ops32[%0d] op %0d result got %h want %h", i, vq[i].op, res, vq[i].res);
      else pass_cnt++;
      total_cnt++;
      if (flg !== vq[i].flg) $display("FAIL ops32[%0d] op %0d flags got %b want %b", i, vq[i].op, flg, vq[i].flg);
      else pass_cnt++;
      total_cnt++;
      if (lat != vq[i].lat) $display("FAIL ops32[%0d] op %0d latency got %0d want %0d", i, vq[i].op, lat, vq[i].lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_mul_stall();
    int lat = 0, guard = 0;
    bit seen_rdy = 1'b0, busy_mid = 1'b0, extra = 1'b0;
    while (!in_ready32 && guard < 100) begin @(negedge clk); guard++; end
    op = 5'd16; a = 32'h00010000; b = 32'h00010000; cin = 1'b0; in_valid32 = 1'b1;
    @(negedge clk);
    op = 5'd0; a = 32'h1; b = 32'h1;           // keeps requesting; must be ignored
    while (!out_valid32 && lat < 200) begin
      if (in_ready32) seen_rdy = 1'b1;
      if (lat == 10) busy_mid = busy32;
      if (lat == 20) in_valid32 = 1'b0;
      @(negedge clk);
      lat++;
    end
    in_valid32 = 1'b0;
    total_cnt++; if (lat != 33) $display("FAIL mul_latency got %0d want 33", lat); else pass_cnt++;
    total_cnt++; if (result32 !== 32'h0) $display("FAIL mul_result got %h want 0", result32); else pass_cnt++;
    total_cnt++; if (flags32 !== 4'b1011) $display("FAIL mul_flags got %b want 1011", flags32); else pass_cnt++;
    total_cnt++; if (seen_rdy !== 1'b0) $display("FAIL calc_in_ready got %b want 0", seen_rdy); else pass_cnt++;
    total_cnt++; if (busy_mid !== 1'b1) $display("FAIL calc_busy got %b want 1", busy_mid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid32 !== 1'b0) $display("FAIL out_valid_pulse got %b want 0", out_valid32); else pass_cnt++;
    repeat (3) begin
      @(negedge clk);
      if (out_valid32) extra = 1'b1;
    end
    total_cnt++; if (extra !== 1'b0) $display("FAIL stall_not_queued got %b want 0", extra); else pass_cnt++;
    total_cnt++; if (flags32 !== 4'b1011) $display("FAIL flags_hold got %b want 1011", flags32); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] res; logic [3:0] flg; int lat, acc;
    bit seen = 1'b0;
    run(1'b0, 5'd0, 32'h77315843, 32'h31539734, 1'b0, res, flg, lat, acc);
    total_cnt++; if (res !== 32'hA884EF77) $display("FAIL pre_abort_result got %h want a884ef77", res); else pass_cnt++;
    // Abort while the next op sits in DONE
    op = 5'd2; a = 32'h1; b = 32'h2; cin = 1'b0; in_valid32 = 1'b1;
    @(negedge clk);
    in_valid32 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++; if (out_valid32 !== 1'b0) $display("FAIL abort_done_valid got %b want 0", out_valid32); else pass_cnt++;
    total_cnt++; if (result32 !== 32'h0) $display("FAIL abort_done_result got %h want 0", result32); else pass_cnt++;
    total_cnt++; if (in_ready32 !== 1'b1) $display("FAIL abort_done_ready got %b want 1", in_ready32); else pass_cnt++;
    repeat (4) begin
      @(negedge clk);
      if (out_valid32) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL abort_done_late_valid got %b want 0", seen); else pass_cnt++;
    // Abort while in CALC
    op = 5'd17; a = 32'd100; b = 32'd7; in_valid32 = 1'b1;
    @(negedge clk);
    in_valid32 = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++; if (busy32 !== 1'b1) $display("FAIL abort_calc_busy got %b want 1", busy32); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++; if (busy32 !== 1'b0) $display("FAIL abort_calc_idle got %b want 0", busy32); else pass_cnt++;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid32) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL abort_calc_valid got %b want 0", seen); else pass_cnt++;
  endtask

  task automatic test_width16();
    logic [31:0] res; logic [3:0] flg; int lat, acc, prev_acc, prev_lat;
    vq.delete();
    add(5'd0,  32'h7731, 32'h3153, 1'b0, 32'hA884, 4'b0101, 1);
    add(5'd1,  32'hFFFF, 32'h0000, 1'b1, 32'h0000, 4'b1010, 1);
    add(5'd2,  32'h0001, 32'h0002, 1'b0, 32'hFFFF, 4'b0110, 1);
    add(5'd3,  32'h0005, 32'h0005, 1'b0, 32'h0000, 4'b1000, 1);
    add(5'd9,  32'h0F0F, 32'h00FF, 1'b0, 32'hFF0F, 4'b0100, 1);
    add(5'd12, 32'h8FF1, 32'd3,    1'b0, 32'hF1FE, 4'b0000, 1);
    add(5'd12, 32'h8FF1, 32'd40,   1'b0, 32'hFFFF, 4'b0000, 1);
    add(5'd10, 32'h8FF1, 32'd16,   1'b0, 32'h0000, 4'b0000, 1);
    add(5'd16, 32'h0100, 32'h0100, 1'b0, 32'h0000, 4'b1011, 17);
    add(5'd16, 32'hFFFF, 32'hFFFF, 1'b0, 32'h0001, 4'b0011, 17);
    add(5'd17, 32'd100,  32'd7,    1'b0, 32'd14,   4'b0000, 17);
    add(5'd18, 32'd100,  32'd7,    1'b0, 32'd2,    4'b0000, 17);
    add(5'd17, 32'd100,  32'd0,    1'b0, 32'hFFFF, 4'b0101, 17);
    add(5'd25, 32'h1234, 32'h0009, 1'b0, 32'h0000, 4'b1001, 1);
    prev_acc = 0; prev_lat = 0;
    for (int i = 0; i < vq.size(); i++) begin
      run(1'b1, vq[i].op, vq[i].a, vq[i].b, vq[i].cin, res, flg, lat, acc);
      total_cnt++;
      if (res !== vq[i].res) $display("FAIL w16[%0d] op %0d result got %h want %h", i, vq[i].op, res, vq[i].res);
      else pass_cnt++;
      total_cnt++;
      if (flg !== vq[i].flg) $display("FAIL w16[%0d] op %0d flags got %b want %b", i, vq[i].op, flg, vq[i].flg);
      else pass_cnt++;
      total_cnt++;
      if (lat != vq[i].lat) $display("FAIL w16[%0d] op %0d latency got %0d want %0d", i, vq[i].op, lat, vq[i].lat);
      else pass_cnt++;
      if (i > 0) begin
        total_cnt++;
        if (acc - prev_acc != prev_lat + 1)
          $display("FAIL w16[%0d] accept spacing got %0d want %0d", i, acc - prev_acc, prev_lat + 1);
        else pass_cnt++;
      end
      prev_acc = acc;
      prev_lat = vq[i].lat;
    end
  endtask

  initial begin
    test_reset();
    test_ops32();
    test_mul_stall();
    test_reset_abort();
    test_width16();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
